// File: rtl/dealer_card_renderer_pkg.sv
// Shared definitions for the dealer card renderer: palette, card_code layout,
// glyph geometry and the walker state encoding.
package dealer_card_renderer_pkg;

  localparam logic [7:0] TABLE_GREEN = 8'h14;
  localparam logic [7:0] BLACK       = 8'h00;
  localparam logic [7:0] WHITE       = 8'hFF;
  localparam logic [7:0] RED         = 8'hE0;
  localparam logic [7:0] BACK_BLUE   = 8'h03;

  localparam int RANK_LSB  = 0;
  localparam int SUIT_LSB  = 4;
  localparam int FACE_BIT  = 6;
  localparam int VALID_BIT = 7;

  localparam int GLYPH_W     = 5;
  localparam int GLYPH_H     = 7;
  localparam int PIP_H       = 5;
  localparam int GLYPH_SCALE = 2;
  localparam int PIP_DY      = 16;

  // ROM indices 0..15 are rank glyphs; the four suit pips follow.
  localparam logic [4:0] PIP_BASE = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [7:0] suit_ink(input logic [1:0] suit);
    return (suit == 2'd1 || suit == 2'd2) ? RED : BLACK;
  endfunction

endpackage

// File: rtl/dealer_card_renderer_glyph_rom.sv
// Combinational 5-pixel-wide bitmap font: rank glyphs (5x7) and suit pips (5x5).
// Bit 4 of the returned row is the leftmost pixel; unknown indices are blank.
module card_glyph_rom
  import dealer_card_renderer_pkg::*;
(
  input  logic [4:0] index,
  input  logic [2:0] row,
  output logic [4:0] bitmap
);

  logic [34:0] art;

  // NOTE: art and bitmap take a default first, so no path through the cases can infer a latch.
  always_comb begin
    art = '0;
    case (index)
      5'd1:  art = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
      5'd2:  art = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
      5'd3:  art = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
      5'd4:  art = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
      5'd5:  art = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
      5'd6:  art = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
      5'd7:  art = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
      5'd8:  art = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
      5'd9:  art = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
      // Ten is drawn as 'T' so every rank fits one 5-wide glyph.
      5'd10: art = {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
      5'd11: art = {5'b00111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b01100};
      5'd12: art = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10010, 5'b01101};
      5'd13: art = {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
      PIP_BASE:         art = {5'b00100, 5'b01110, 5'b11111, 5'b00100, 5'b01110, 10'b0};
      PIP_BASE + 5'd1:  art = {5'b01010, 5'b11111, 5'b11111, 5'b01110, 5'b00100, 10'b0};
      PIP_BASE + 5'd2:  art = {5'b00100, 5'b01110, 5'b11111, 5'b01110, 5'b00100, 10'b0};
      PIP_BASE + 5'd3:  art = {5'b01110, 5'b01110, 5'b11111, 5'b00100, 5'b01110, 10'b0};
      default: art = '0;
    endcase

    bitmap = '0;
    case (row)
      3'd0: bitmap = art[34:30];
      3'd1: bitmap = art[29:25];
      3'd2: bitmap = art[24:20];
      3'd3: bitmap = art[19:15];
      3'd4: bitmap = art[14:10];
      3'd5: bitmap = art[9:5];
      3'd6: bitmap = art[4:0];
      default: bitmap = '0;
    endcase
  end

endmodule

// File: rtl/dealer_card_renderer.sv
// Redraws one card sprite into the framebuffer whenever the dealer card code changes,
// walking the card row-major with valid/ready backpressure on the write port.
module dealer_card_renderer
  import dealer_card_renderer_pkg::*;
#(
  parameter int X0     = 16,
  parameter int Y0     = 16,
  parameter int CARD_W = 32,
  parameter int CARD_H = 48,
  parameter int FB_W   = 320,
  parameter int ADDR_W = 17,
  parameter int GX     = 4,
  parameter int GY     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        card_code,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_we,
  input  logic              fb_ready,
  output logic              busy,
  output logic              done
);

  localparam int XW = $clog2(CARD_W);
  localparam int YW = $clog2(CARD_H);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(Y0 * FB_W + X0);
  localparam logic [ADDR_W-1:0] PITCH     = ADDR_W'(FB_W);
  localparam logic [XW-1:0]     X_LAST    = XW'(CARD_W - 1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(CARD_H - 1);

  state_t            state;
  logic [7:0]        cur;
  logic [7:0]        last_drawn;
  logic              dirty;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;

  // Coordinates of the pixel to present next: (0,0) from IDLE, else the successor of (x,y).
  logic [7:0]        px_code;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic [ADDR_W-1:0] px_row_base;
  logic [ADDR_W-1:0] px_addr;

  always_comb begin
    px_code     = cur;
    px_x        = x + XW'(1);
    px_y        = y;
    px_row_base = row_base;
    if (state == IDLE) begin
      px_code     = card_code;
      px_x        = '0;
      px_y        = '0;
      px_row_base = BASE_ADDR;
    end else if (x == X_LAST) begin
      px_x        = '0;
      px_y        = y + YW'(1);
      px_row_base = row_base + PITCH;
    end
    px_addr = px_row_base + ADDR_W'(px_x);
  end

  logic [11:0] ux;
  logic [11:0] uy;
  logic        border;
  logic        in_glyph;
  logic        in_pip;
  logic [2:0]  col;
  logic [4:0]  rom_index;
  logic [2:0]  rom_row;
  logic [4:0]  rom_bits;
  logic [7:0]  pixel;

  // Glyph and pip boxes never overlap, so one ROM port serves both.
  always_comb begin
    ux       = 12'(px_x);
    uy       = 12'(px_y);
    border   = (px_x == '0) || (px_y == '0) || (px_x == X_LAST) || (px_y == Y_LAST);
    in_glyph = (ux >= 12'(GX)) && (ux < 12'(GX + GLYPH_W * GLYPH_SCALE)) &&
               (uy >= 12'(GY)) && (uy < 12'(GY + GLYPH_H * GLYPH_SCALE));
    in_pip   = (ux >= 12'(GX)) && (ux < 12'(GX + GLYPH_W * GLYPH_SCALE)) &&
               (uy >= 12'(GY + PIP_DY)) && (uy < 12'(GY + PIP_DY + PIP_H * GLYPH_SCALE));
    col       = 3'((ux - 12'(GX)) >> 1);
    rom_index = {1'b0, px_code[RANK_LSB +: 4]};
    rom_row   = 3'((uy - 12'(GY)) >> 1);
    if (in_pip) begin
      rom_index = PIP_BASE + {3'b000, px_code[SUIT_LSB +: 2]};
      rom_row   = 3'((uy - 12'(GY + PIP_DY)) >> 1);
    end
  end

  card_glyph_rom u_rom (
    .index  (rom_index),
    .row    (rom_row),
    .bitmap (rom_bits)
  );

  always_comb begin
    pixel = WHITE;
    if (!px_code[VALID_BIT]) begin
      pixel = TABLE_GREEN;
    end else if (border) begin
      pixel = BLACK;
    end else if (px_code[FACE_BIT]) begin
      pixel = BACK_BLUE;
    end else if ((in_glyph || in_pip) && rom_bits[3'd4 - col]) begin
      pixel = suit_ink(px_code[SUIT_LSB +: 2]);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur        <= '0;
      last_drawn <= '0;
      dirty      <= 1'b1;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      fb_addr    <= '0;
      fb_data    <= '0;
      fb_we      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (dirty || card_code != last_drawn) begin
            cur        <= card_code;
            last_drawn <= card_code;
            dirty      <= 1'b0;
            x          <= px_x;
            y          <= px_y;
            row_base   <= px_row_base;
            fb_addr    <= px_addr;
            fb_data    <= pixel;
            fb_we      <= 1'b1;
            busy       <= 1'b1;
            state      <= DRAW;
          end
        end
        DRAW: begin
          // Address and data stay put until the arbiter takes them.
          if (fb_ready) begin
            if (x == X_LAST && y == Y_LAST) begin
              fb_we <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              x        <= px_x;
              y        <= px_y;
              row_base <= px_row_base;
              fb_addr  <= px_addr;
              fb_data  <= pixel;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dealer_card_renderer.sv
// Directed and randomized bench for dealer_card_renderer: captures every accepted
// framebuffer write and compares each draw with a behavioural card painter.
module tb_dealer_card_renderer;

  localparam int W    = 32;
  localparam int H    = 48;
  localparam int FBW  = 320;
  localparam int X0   = 16;
  localparam int Y0   = 16;
  localparam int GX   = 4;
  localparam int GY   = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  card_code;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dealer_card_renderer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .card_code (card_code),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_we     (fb_we),
    .fb_ready  (fb_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         writes[$];
  int          done_count;
  int          stall_errs;
  int          checks;
  int          failures;
  bit          ready_rand;
  logic        prev_stall;
  logic [16:0] prev_addr;
  logic [7:0]  prev_data;

  // Write monitor: a write presented here is taken at the next rising edge.
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && fb_we === 1'b1 && (fb_addr !== prev_addr || fb_data !== prev_data))
        stall_errs++;
      if (fb_we === 1'b1 && fb_ready === 1'b1) writes.push_back('{addr: fb_addr, data: fb_data});
      if (done === 1'b1) done_count++;
      prev_stall = (fb_we === 1'b1 && fb_ready === 1'b0);
      prev_addr  = fb_addr;
      prev_data  = fb_data;
    end
  end

  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fb_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string glyph_art(input int rank);
    case (rank)
      1:  return {".###.", "#...#", "#...#", "#####", "#...#", "#...#", "#...#"};
      2:  return {".###.", "#...#", "....#", "...#.", "..#..", ".#...", "#####"};
      3:  return {"#####", "...#.", "..#..", "...#.", "....#", "#...#", ".###."};
      4:  return {"...#.", "..##.", ".#.#.", "#..#.", "#####", "...#.", "...#."};
      5:  return {"#####", "#....", "####.", "....#", "....#", "#...#", ".###."};
      6:  return {"..##.", ".#...", "#....", "####.", "#...#", "#...#", ".###."};
      7:  return {"#####", "....#", "...#.", "..#..", ".#...", ".#...", ".#..."};
      8:  return {".###.", "#...#", "#...#", ".###.", "#...#", "#...#", ".###."};
      9:  return {".###.", "#...#", "#...#", ".####", "....#", "...#.", ".##.."};
      10: return {"#####", "..#..", "..#..", "..#..", "..#..", "..#..", "..#.."};
      11: return {"..###", "...#.", "...#.", "...#.", "...#.", "#..#.", ".##.."};
      12: return {".###.", "#...#", "#...#", "#...#", "#.#.#", "#..#.", ".##.#"};
      13: return {"#...#", "#..#.", "#.#..", "##...", "#.#..", "#..#.", "#...#"};
      default: return "";
    endcase
  endfunction

  function automatic string pip_art(input int suit);
    case (suit)
      0:       return {"..#..", ".###.", "#####", "..#..", ".###."};
      1:       return {".#.#.", "#####", "#####", ".###.", "..#.."};
      2:       return {"..#..", ".###.", "#####", ".###.", "..#.."};
      default: return {".###.", ".###.", "#####", "..#..", ".###."};
    endcase
  endfunction

  function automatic logic [7:0] model_pixel(input logic [7:0] code, input int x, input int y);
    int rank, suit, col, row;
    string art;
    logic [7:0] ink;
    rank = int'(code[3:0]);
    suit = int'(code[5:4]);
    ink  = (suit == 1 || suit == 2) ? 8'hE0 : 8'h00;
    if (!code[7]) return 8'h14;
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 8'h00;
    if (code[6]) return 8'h03;
    col = (x - GX) / 2;
    if (x >= GX && x < GX + 10 && y >= GY && y < GY + 14) begin
      art = glyph_art(rank);
      row = (y - GY) / 2;
    end else if (x >= GX && x < GX + 10 && y >= GY + 16 && y < GY + 26) begin
      art = pip_art(suit);
      row = (y - GY - 16) / 2;
    end else begin
      return 8'hFF;
    end
    if (art.len() > 0 && art[row * 5 + col] == "#") return ink;
    return 8'hFF;
  endfunction

  // Compares NPIX captured writes starting at index first against one expected card.
  task automatic check_draw(input string tag, input logic [7:0] code, input int first);
    int addr_errs, data_errs;
    addr_errs = 0;
    data_errs = 0;
    for (int i = 0; i < NPIX; i++) begin
      int px, py, idx;
      px  = i % W;
      py  = i / W;
      idx = first + i;
      if (idx >= writes.size()) begin
        addr_errs++;
        data_errs++;
      end else begin
        if (int'(writes[idx].addr) != (Y0 + py) * FBW + X0 + px) addr_errs++;
        if (writes[idx].data !== model_pixel(code, px, py)) data_errs++;
      end
    end
    check({tag, "_addr_errs"}, 32'(addr_errs), 0);
    check({tag, "_data_errs"}, 32'(data_errs), 0);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_count), 32'(target));
  endtask

  task automatic start_draw(input logic [7:0] code);
    @(negedge clk);
    card_code  = code;
    writes.delete();
    done_count = 0;
  endtask

  logic [7:0] last_code;
  logic [7:0] codes[6];

  initial begin
    checks     = 0;
    failures   = 0;
    stall_errs = 0;
    done_count = 0;
    ready_rand = 1'b0;
    reset_n    = 1'b0;
    card_code  = 8'h00;

    // Reset state, then the forced draw of an invalid code (table green erase).
    repeat (3) @(negedge clk);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_data), 0);
    writes.delete();
    reset_n = 1'b1;
    wait_done("erase", 1, 4000);
    check("erase_count", 32'(writes.size()), 1536);
    check_draw("erase", 8'h00, 0);
    check("erase_first_addr", 32'(writes[0].addr), 5136);
    check("erase_last_addr", 32'(writes[writes.size() - 1].addr), 20207);
    repeat (10) @(negedge clk);
    check("erase_idle_busy", 32'(busy), 0);
    check("erase_idle_we", 32'(fb_we), 0);
    check("erase_no_redraw", 32'(writes.size()), 1536);

    // Ace of hearts: first write one cycle after the change.
    start_draw(8'h91);
    @(negedge clk);
    check("ace_first_we", 32'(fb_we), 1);
    check("ace_first_busy", 32'(busy), 1);
    check("ace_first_addr", 32'(fb_addr), 5136);
    wait_done("ace", 1, 4000);
    check("ace_count", 32'(writes.size()), 1536);
    check_draw("ace", 8'h91, 0);
    check("ace_px_0_0", 32'(writes[0].data), 32'h00);
    check("ace_px_1_1", 32'(writes[1 * W + 1].data), 32'hFF);
    check("ace_px_6_4", 32'(writes[4 * W + 6].data), 32'hE0);

    // Same card under random backpressure, forced by a reset.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    writes.delete();
    done_count = 0;
    stall_errs = 0;
    ready_rand = 1'b1;
    reset_n    = 1'b1;
    wait_done("ace_stall", 1, 8000);
    check("ace_stall_count", 32'(writes.size()), 1536);
    check_draw("ace_stall", 8'h91, 0);
    check("ace_stall_stable", 32'(stall_errs), 0);

    // Codes changing mid-draw: only the latest one is drawn afterwards.
    start_draw(8'h8D);
    repeat (100) @(negedge clk);
    card_code = 8'hAC;
    repeat (3) @(negedge clk);
    card_code = 8'h8C;
    wait_done("coalesce", 2, 16000);
    repeat (20) @(negedge clk);
    check("coalesce_count", 32'(writes.size()), 3072);
    check_draw("coalesce_8d", 8'h8D, 0);
    check_draw("coalesce_8c", 8'h8C, NPIX);
    check("coalesce_stable", 32'(stall_errs), 0);

    // Face-down card, with a bounce back to the same code mid-draw.
    ready_rand = 1'b0;
    start_draw(8'hC5);
    repeat (50) @(negedge clk);
    card_code = 8'h12;
    repeat (3) @(negedge clk);
    card_code = 8'hC5;
    wait_done("back", 1, 4000);
    repeat (20) @(negedge clk);
    check("back_count", 32'(writes.size()), 1536);
    check("back_no_redraw", 32'(done_count), 1);
    check_draw("back", 8'hC5, 0);
    check("back_px_0_5", 32'(writes[5 * W].data), 32'h00);
    check("back_px_6_4", 32'(writes[4 * W + 6].data), 32'h03);
    last_code = 8'hC5;

    // Ten, out-of-range ranks, then random codes under random backpressure.
    codes[0] = 8'hBA;
    codes[1] = 8'hAE;
    codes[2] = 8'h80;
    for (int i = 3; i < 6; i++) begin
      codes[i] = 8'($urandom);
      while (codes[i] == codes[i - 1]) codes[i] = 8'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      ready_rand = (i >= 3);
      stall_errs = 0;
      start_draw(codes[i]);
      wait_done($sformatf("card%0d_%02h", i, codes[i]), 1, 8000);
      check($sformatf("card%0d_count", i), 32'(writes.size()), 1536);
      check_draw($sformatf("card%0d", i), codes[i], 0);
      check($sformatf("card%0d_stable", i), 32'(stall_errs), 0);
      last_code = codes[i];
    end

    // Reset after 700 accepted pixels, then a full redraw of the current code.
    ready_rand = 1'b0;
    start_draw(last_code == 8'hB7 ? 8'hB6 : 8'hB7);
    begin
      int n;
      n = 0;
      while (writes.size() < 700 && n < 4000) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_mid_reached", 32'(writes.size()), 700);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_we_low", 32'(fb_we), 0);
    check("rst_mid_busy_low", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    writes.delete();
    done_count = 0;
    reset_n    = 1'b1;
    wait_done("redraw", 1, 4000);
    check("redraw_count", 32'(writes.size()), 1536);
    check_draw("redraw", card_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
